descrambler_multiblock: RTL and testbench
=========================================

// Module: descrambler_multiblock
// PURPOSE
//  Parallel self-synchronising descrambler, polynomial 1+x^39+x^58. Per clock it handles
//  NB_BLOCKS 66-bit coded blocks, in one valid-qualified pipeline stage.
//  Sits after block sync/alignment and before the 64b/66b decoder in the RX datapath.
//  Adds four things over the single-block descrambler:
//  - multi-block words;
//  - valid gating of the LFSR state;
//  - a seeded (warm-up) flag;
//  - a saturating invalid-sync-header counter.
// PARAMETERS
//  NB_BLOCKS        2    blocks per word; 1..4
//  LEN_CODED_BLOCK  66   bits per coded block (2 SH + 64 payload)
//  LEN_SCRAMBLER    58   LFSR length
//  SEED             0    LFSR state after reset
//  NB_ERR_CNT       16   width of sync-header error counter
// PORTS
//  i_clock          in   1                      clock
//  i_reset_n        in   1                      async reset, active low
//  i_enable         in   1                      global clock enable
//  i_valid          in   1                      i_data/i_tag qualify this cycle
//  i_bypass         in   1                      pass data unscrambled; LFSR frozen
//  i_clear_count    in   1                      sync clear of o_sh_err_count
//  i_data           in   NB_BLOCKS*66           block 0 = MSBs = oldest in time
//  i_tag            in   NB_BLOCKS              per-block sideband, carried through
//  o_data           out  NB_BLOCKS*66           descrambled (or bypassed) word
//  o_tag            out  NB_BLOCKS              i_tag delayed to align with o_data
//  o_valid          out  1                      o_data/o_tag valid
//  o_seeded         out  1                      o_data fully descrambled by received-data state
//  o_sh_err_count   out  NB_ERR_CNT             saturating count of blocks with SH 00/11
// BEHAVIOUR
//  - Reset (async assert, sync release):
//    - o_data=0, o_tag=0, o_valid=0, o_seeded=0, o_sh_err_count=0;
//    - LFSR state=SEED; internal warm-up flag=0.
//  - Accept = i_enable & i_valid. Latency is 1 cycle: o_valid <= i_enable & i_valid.
//  - On non-accept cycles, o_data/o_tag/o_seeded hold and the LFSR holds.
//  - Descramble is serial-equivalent. Blocks run 0..NB_BLOCKS-1; within a block, payload bits 63..0.
//    - out = in ^ s[38] ^ s[57], where s[0] is the most recent received bit.
//    - Then shift the received (scrambled) bit into s[0].
//    - SH bits pass through untouched.
//    - State after block k feeds block k+1 in the same cycle.
//  - Accept & !i_bypass:
//    - o_data = descrambled word;
//    - LFSR <= state after last block.
//  - Accept & i_bypass:
//    - o_data = i_data;
//    - LFSR frozen;
//    - warm-up flag cleared; o_seeded <= 0.
//  - Seeding:
//    - The first accepted non-bypass word after reset or bypass exit uses stale state, so o_seeded <= 0 with it.
//    - The warm-up flag is set at that accept (58 < 64 bits).
//    - Every later non-bypass accept gives o_seeded <= 1.
//  - Sync-header check, on every accept, bypass included:
//    - n = number of blocks with SH in {2'b00, 2'b11};
//    - count <= min(count + n, 2^NB_ERR_CNT - 1).
//  - i_clear_count has priority over increment: count <= 0 that cycle, the increment is dropped.
//  - i_clear_count acts even when i_enable=0.
//  - i_enable=0 freezes everything except i_clear_count. o_valid <= 0.
//  - Reset mid-stream: LFSR returns to SEED; the next accepted word is unseeded.
// STRUCTURE
//  - Shared package (pcs_pkg):
//    - LEN_CODED_BLOCK, LEN_SCRAMBLER, NB_SH;
//    - tap constants 38/57;
//    - SH_DATA=2'b01, SH_CTRL=2'b10.
//  - Sub-module descrambler_block_slice: combinational, one 66-bit block.
//    - Inputs: state, block. Outputs: descrambled block, next state, sh_invalid.
//    - Chained NB_BLOCKS times by generate.
//  - Top holds the LFSR, output registers, seed flag and error counter.
// TESTING
//  1. NB_BLOCKS=1, SEED=0. Word A = {2'b01, 64'h1}, then word B = {2'b01, 64'h0}.
//     -> A out = {2'b01, 64'h1}, o_seeded=0.
//     -> B out = {2'b01, 64'h0000_0000_0200_0040}, o_seeded=1.
//  2. Round trip with a reference scrambler model, 1000 random words, NB_BLOCKS=1..4.
//     -> From the second accepted word on, o_data == pre-scramble data; o_valid follows i_valid by 1 cycle.
//  3. Toggle i_valid=0 for 5 cycles mid-stream.
//     -> Output stream identical to the gap-free run; o_data holds during the gap.
//  4. Assert i_bypass for 3 words.
//     -> o_data == i_data and o_seeded=0 for those words.
//     -> The first word after bypass has o_seeded=0; the next has o_seeded=1.
//  5. NB_BLOCKS=2, SH {00,11} on every word, 40000 words.
//     -> Count increments by 2 per word and saturates at 16'hFFFF.
//     -> i_clear_count in the same cycle as an increment -> 0.
//  6. Assert i_reset_n low for 1 cycle asynchronously mid-burst.
//     -> All outputs 0 immediately; the first word after release is unseeded, consistent with SEED.

Source files
------------

// File: rtl/pcs_pkg.sv
// Shared PCS constants for the RX datapath.
// Block geometry, scrambler taps and sync-header codes.
package pcs_pkg;

    localparam int LEN_CODED_BLOCK = 66;
    localparam int LEN_SCRAMBLER   = 58;
    localparam int NB_SH           = 2;
    localparam int LEN_PAYLOAD     = LEN_CODED_BLOCK - NB_SH;

    localparam int TAP_A = 38;
    localparam int TAP_B = 57;

    localparam logic [NB_SH-1:0] SH_DATA = 2'b01;
    localparam logic [NB_SH-1:0] SH_CTRL = 2'b10;

endpackage

// File: rtl/descrambler_block_slice.sv
// One 66-bit block of the self-synchronising descrambler.
// Pure combinational; slices chain state to state within a word.
module descrambler_block_slice
    import pcs_pkg::*;
(
    input  logic [LEN_SCRAMBLER-1:0]   i_state,
    input  logic [LEN_CODED_BLOCK-1:0] i_block,
    output logic [LEN_CODED_BLOCK-1:0] o_block,
    output logic [LEN_SCRAMBLER-1:0]   o_state,
    output logic                       o_sh_invalid
);

    logic [LEN_SCRAMBLER-1:0] st;
    logic [NB_SH-1:0]         sh;

    assign sh = i_block[LEN_CODED_BLOCK-1 -: NB_SH];

    // Only the two legal sync headers are accepted.
    assign o_sh_invalid = (sh != SH_DATA) && (sh != SH_CTRL);

    // Serial-equivalent descramble, MSB payload bit first.
    always_comb begin
        st      = i_state;
        o_block = i_block;
        for (int i = LEN_PAYLOAD - 1; i >= 0; i--) begin
            o_block[i] = i_block[i] ^ st[TAP_A] ^ st[TAP_B];
            st = {st[LEN_SCRAMBLER-2:0], i_block[i]};
        end
        o_state = st;
    end

endmodule

// File: rtl/descrambler_multiblock.sv
// Multi-block 1+x^39+x^58 descrambler with valid gating,
// warm-up tracking and a saturating sync-header error count.
module descrambler_multiblock #(
    parameter int                          NB_BLOCKS       = 2,
    parameter int                          LEN_CODED_BLOCK = 66,
    parameter int                          LEN_SCRAMBLER   = 58,
    parameter logic [LEN_SCRAMBLER-1:0]    SEED            = '0,
    parameter int                          NB_ERR_CNT      = 16
) (
    input  logic                                 i_clock,
    input  logic                                 i_reset_n,
    input  logic                                 i_enable,
    input  logic                                 i_valid,
    input  logic                                 i_bypass,
    input  logic                                 i_clear_count,
    input  logic [NB_BLOCKS*LEN_CODED_BLOCK-1:0] i_data,
    input  logic [NB_BLOCKS-1:0]                 i_tag,
    output logic [NB_BLOCKS*LEN_CODED_BLOCK-1:0] o_data,
    output logic [NB_BLOCKS-1:0]                 o_tag,
    output logic                                 o_valid,
    output logic                                 o_seeded,
    output logic [NB_ERR_CNT-1:0]                o_sh_err_count
);

    import pcs_pkg::*;

    localparam int W  = NB_BLOCKS * LEN_CODED_BLOCK;
    localparam int CW = NB_ERR_CNT + 1;

    logic [LEN_SCRAMBLER-1:0] lfsr;
    logic [LEN_SCRAMBLER-1:0] chain [NB_BLOCKS+1];
    logic [W-1:0]             dsc;
    logic [NB_BLOCKS-1:0]     sh_bad;
    logic                     warm;
    logic                     accept;
    logic [CW-1:0]            cnt_sum;
    logic [NB_ERR_CNT-1:0]    cnt_next;

    assign accept   = i_enable & i_valid;
    assign chain[0] = lfsr;

    for (genvar g = 0; g < NB_BLOCKS; g++) begin : g_slice
        descrambler_block_slice u_slice (
            .i_state      (chain[g]),
            .i_block      (i_data[W-1-g*LEN_CODED_BLOCK -: LEN_CODED_BLOCK]),
            .o_block      (dsc[W-1-g*LEN_CODED_BLOCK -: LEN_CODED_BLOCK]),
            .o_state      (chain[g+1]),
            .o_sh_invalid (sh_bad[g])
        );
    end

    // Add this word's bad headers, clamping at all-ones.
    always_comb begin
        cnt_sum  = {1'b0, o_sh_err_count} + CW'($countones(sh_bad));
        cnt_next = cnt_sum[NB_ERR_CNT] ? '1 : cnt_sum[NB_ERR_CNT-1:0];
    end

    // Datapath, LFSR and warm-up tracking; bypass freezes the LFSR.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            lfsr     <= SEED;
            warm     <= 1'b0;
            o_data   <= '0;
            o_tag    <= '0;
            o_valid  <= 1'b0;
            o_seeded <= 1'b0;
        end else begin
            o_valid <= accept;
            if (accept) begin
                o_tag <= i_tag;
                if (i_bypass) begin
                    o_data   <= i_data;
                    o_seeded <= 1'b0;
                    warm     <= 1'b0;
                end else begin
                    o_data   <= dsc;
                    o_seeded <= warm;
                    warm     <= 1'b1;
                    lfsr     <= chain[NB_BLOCKS];
                end
            end
        end
    end

    // Error counter; clear wins and works without enable.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_sh_err_count <= '0;
        end else if (i_clear_count) begin
            o_sh_err_count <= '0;
        end else if (accept) begin
            o_sh_err_count <= cnt_next;
        end
    end

endmodule

// File: tb/tb_descrambler_multiblock.sv
// Bench for descrambler_multiblock (NB_BLOCKS=2, SEED=0).
// Bit-history model plus reference scrambler for round trips.
module tb_descrambler_multiblock;

    localparam int NB = 2;
    localparam int W  = NB * 66;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          vld = 1'b0;
    logic          byp = 1'b0;
    logic          clr = 1'b0;
    logic [W-1:0]  din = '0;
    logic [NB-1:0] tin = '0;
    logic [W-1:0]  o_data;
    logic [NB-1:0] o_tag;
    logic          o_valid;
    logic          o_seeded;
    logic [CW-1:0] o_cnt;

    int n_chk = 0;
    int n_fail = 0;

    bit rxq[$];
    bit txq[$];
    logic [W-1:0]  e_data;
    logic [NB-1:0] e_tag;
    logic          e_vld;
    logic          e_seed;
    int            e_cnt;
    int            warm_n;

    descrambler_multiblock #(
        .NB_BLOCKS(NB), .LEN_CODED_BLOCK(66), .LEN_SCRAMBLER(58),
        .SEED('0), .NB_ERR_CNT(CW)
    ) dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_enable(en),
        .i_valid(vld), .i_bypass(byp), .i_clear_count(clr),
        .i_data(din), .i_tag(tin), .o_data(o_data), .o_tag(o_tag),
        .o_valid(o_valid), .o_seeded(o_seeded), .o_sh_err_count(o_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Received line bits: newest at the back; s[k] is k bits back.
    function automatic logic [65:0] model_block(input logic [65:0] b);
        logic [65:0] r = b;
        for (int i = 63; i >= 0; i--) begin
            r[i] = b[i] ^ rxq[rxq.size()-39] ^ rxq[rxq.size()-58];
            rxq.push_back(b[i]);
        end
        while (rxq.size() > 64) void'(rxq.pop_front());
        return r;
    endfunction

    // Transmit-side scrambler: history of sent scrambled bits.
    function automatic logic [W-1:0] scramble(input logic [W-1:0] p);
        logic [W-1:0] r = p;
        for (int b = 0; b < NB; b++) begin
            for (int i = 63; i >= 0; i--) begin
                int k = W - 1 - b * 66 - (65 - i);
                r[k] = p[k] ^ txq[txq.size()-39] ^ txq[txq.size()-58];
                txq.push_back(r[k]);
            end
        end
        while (txq.size() > 64) void'(txq.pop_front());
        return r;
    endfunction

    function automatic logic [W-1:0] rand_plain(input bit bad);
        logic [W-1:0] r;
        for (int b = 0; b < NB; b++) begin
            logic [1:0] sh;
            if (bad) sh = (b % 2 == 1) ? 2'b11 : 2'b00;
            else     sh = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
            r[W-1-b*66 -: 66] = {sh, $urandom(), $urandom()};
        end
        return r;
    endfunction

    task automatic model_reset();
        rxq.delete();
        txq.delete();
        repeat (58) begin
            rxq.push_back(1'b0);
            txq.push_back(1'b0);
        end
        e_data = '0; e_tag = '0; e_vld = 0; e_seed = 0;
        e_cnt = 0; warm_n = 0;
    endtask

    task automatic model_edge();
        int nbad = 0;
        for (int b = 0; b < NB; b++) begin
            logic [1:0] sh = din[W-1-b*66 -: 2];
            if (sh == 2'b00 || sh == 2'b11) nbad++;
        end
        if (clr) e_cnt = 0;
        else if (en && vld) begin
            e_cnt = e_cnt + nbad;
            if (e_cnt > 65535) e_cnt = 65535;
        end
        e_vld = en && vld;
        if (en && vld) begin
            e_tag = tin;
            if (byp) begin
                e_data = din; e_seed = 0; warm_n = 0;
            end else begin
                for (int b = 0; b < NB; b++)
                    e_data[W-1-b*66 -: 66] = model_block(din[W-1-b*66 -: 66]);
                e_seed = (warm_n > 0);
                warm_n++;
            end
        end
    endtask

    // Every cycle out of reset, outputs must match the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("o_valid", W'(o_valid), W'(e_vld));
            chk("o_data", o_data, e_data);
            chk("o_tag", W'(o_tag), W'(e_tag));
            chk("o_seeded", W'(o_seeded), W'(e_seed));
            chk("o_sh_err_count", W'(o_cnt), W'(e_cnt));
        end
    end

    task automatic drive(input bit e, input bit v, input bit b, input bit c,
                         input logic [W-1:0] d, input logic [NB-1:0] t);
        en = e; vld = v; byp = b; clr = c; din = d; tin = t;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    logic [W-1:0] p, s, hold;

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset o_data", o_data, '0);
        chk("reset o_valid", W'(o_valid), '0);
        chk("reset o_seeded", W'(o_seeded), '0);
        chk("reset count", W'(o_cnt), '0);
        rst_n = 1'b1;

        // Single 1 then zeros: taps fire at bits 25 and 6.
        drive(1, 1, 0, 0, {2'b01, 64'h1, 2'b01, 64'h0}, 2'b10);
        chk("t1 word A", o_data,
            {2'b01, 64'h1, 2'b01, 64'h0000_0000_0200_0040});
        chk("t1 seeded A", W'(o_seeded), W'(1'b0));
        chk("t1 tag", W'(o_tag), W'(2'b10));
        drive(1, 1, 0, 0, {2'b01, 64'h0, 2'b01, 64'h0}, 2'b01);
        chk("t1 word B", o_data, {2'b01, 64'h0, 2'b01, 64'h0});
        chk("t1 seeded B", W'(o_seeded), W'(1'b1));

        // Round trip through the reference scrambler.
        txq = rxq;
        for (int n = 0; n < 300; n++) begin
            bit v = ($urandom_range(0, 7) != 0);
            p = rand_plain(0);
            s = v ? scramble(p) : rand_plain(0);
            drive(1, v, 0, 0, s, 2'($urandom()));
            if (v) chk("t2 round trip", o_data, p);
        end

        // Valid gap and enable-low cycles: outputs hold.
        hold = o_data;
        repeat (5) drive(1, 0, 0, 0, rand_plain(0), 2'($urandom()));
        repeat (2) drive(0, 1, 0, 0, rand_plain(1), 2'($urandom()));
        chk("t3 hold", o_data, hold);
        p = rand_plain(0);
        drive(1, 1, 0, 0, scramble(p), 2'b11);
        chk("t3 after gap", o_data, p);

        // Bypass for 3 words, then warm-up again.
        for (int n = 0; n < 3; n++) begin
            s = rand_plain(0);
            drive(1, 1, 1, 0, s, 2'b01);
            chk("t4 bypass data", o_data, s);
            chk("t4 bypass seeded", W'(o_seeded), '0);
        end
        drive(1, 1, 0, 0, scramble(rand_plain(0)), 2'b00);
        chk("t4 first after bypass", W'(o_seeded), '0);
        p = rand_plain(0);
        drive(1, 1, 0, 0, scramble(p), 2'b00);
        chk("t4 second after bypass", W'(o_seeded), W'(1'b1));
        chk("t4 round trip", o_data, p);

        // Error counter: clear priority, clear without enable, saturation.
        drive(1, 1, 0, 1, rand_plain(1), 2'b00);
        chk("t5 clear wins", W'(o_cnt), '0);
        drive(1, 1, 0, 0, rand_plain(1), 2'b00);
        chk("t5 plus two", W'(o_cnt), W'(16'd2));
        drive(0, 0, 0, 1, rand_plain(1), 2'b00);
        chk("t5 clear no enable", W'(o_cnt), '0);
        for (int n = 0; n < 32770; n++)
            drive(1, 1, 0, 0, rand_plain(1), 2'($urandom()));
        chk("t5 saturated", W'(o_cnt), W'(16'hFFFF));
        drive(1, 1, 1, 0, rand_plain(1), 2'b00);
        chk("t5 stays saturated", W'(o_cnt), W'(16'hFFFF));
        drive(1, 1, 0, 1, rand_plain(1), 2'b00);
        chk("t5 clear at saturation", W'(o_cnt), '0);

        // Asynchronous reset mid-burst.
        repeat (3) drive(1, 1, 0, 0, rand_plain(0), 2'b11);
        vld = 1'b1; din = rand_plain(1);
        @(posedge clk);
        model_edge();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6 async o_data", o_data, '0);
        chk("t6 async o_valid", W'(o_valid), '0);
        chk("t6 async o_tag", W'(o_tag), '0);
        chk("t6 async count", W'(o_cnt), '0);
        @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        p = rand_plain(0);
        drive(1, 1, 0, 0, scramble(p), 2'b10);
        chk("t6 first after reset", o_data, p);
        chk("t6 unseeded", W'(o_seeded), '0);
        p = rand_plain(0);
        drive(1, 1, 0, 0, scramble(p), 2'b10);
        chk("t6 second after reset", o_data, p);
        chk("t6 seeded", W'(o_seeded), W'(1'b1));

        drive(0, 0, 0, 0, '0, '0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
